spi_slave_regfile: RTL and testbench

SPI_SLAVE_REGFILE -- requirements
Module: spi_slave_regfile

---
 rtl/spi_regfile_pkg.sv | 27 ++
 rtl/spi_slave_regfile_if.sv | 26 ++
 rtl/spi_sync_edge.sv | 35 +++
 rtl/spi_slave_regfile.sv | 150 +++++++++++++++
 tb/tb_spi_slave_regfile.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/spi_regfile_pkg.sv
// Shared types and constants for the SPI slave register file.
// The command byte carries a write flag in its MSB and a start address in its low bits.
package spi_regfile_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StData
  } state_e;

  localparam int unsigned NUM_REGS_DEFAULT = 6;
  localparam int unsigned CMD_WR_BIT       = 7;
  localparam int unsigned CMD_ADDR_MSB     = 2;
  localparam int unsigned CMD_ADDR_LSB     = 0;
  localparam int unsigned ADDR_W           = CMD_ADDR_MSB - CMD_ADDR_LSB + 1;
  localparam logic [7:0]  INVALID_RD       = 8'h00;

  // Unimplemented addresses still step upward so they wrap through the top of the field to 0.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input int unsigned       num_regs);
    logic [ADDR_W-1:0] nxt;
    nxt = addr + 1'b1;
    if (addr == ADDR_W'(num_regs - 1)) nxt = '0;
    return nxt;
  endfunction

endpackage

// File: rtl/spi_slave_regfile_if.sv
// SPI pins plus register-file outputs bundled for the slave and its environment.
interface spi_slave_regfile_if
  import spi_regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT
);

  logic       sclk;
  logic       mosi;
  logic       ss_n;
  logic       miso;
  logic [7:0] slv_reg [NUM_REGS];
  logic       wr_strobe;
  logic       busy;

  modport slave (
    input  sclk, mosi, ss_n,
    output miso, slv_reg, wr_strobe, busy
  );

  modport master (
    output sclk, mosi, ss_n,
    input  miso, slv_reg, wr_strobe, busy
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input with rise/fall detection
// on the synchronized level.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_q    = r_sync[SYNC_STAGES-1];
  assign o_rise = o_q & ~r_prev;
  assign o_fall = ~o_q & r_prev;

endmodule

// File: rtl/spi_slave_regfile.sv
// Mode-0 SPI slave giving read/write access to a small bank of byte registers.
// A command byte selects direction and start address; following bytes auto-increment.
module spi_slave_regfile
  import spi_regfile_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_REGS    = NUM_REGS_DEFAULT
) (
  input logic                i_clk,
  input logic                i_rst_n,
  spi_slave_regfile_if.slave spi
);

  logic w_sclk_rise, w_sclk_fall, w_sclk_q;
  logic w_mosi_q, w_mosi_rise, w_mosi_fall;
  logic w_ss_q, w_ss_rise, w_ss_fall;
  logic w_unused_sync;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (spi.sclk),
    .o_q     (w_sclk_q),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (spi.mosi),
    .o_q     (w_mosi_q),
    .o_rise  (w_mosi_rise),
    .o_fall  (w_mosi_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (spi.ss_n),
    .o_q     (w_ss_q),
    .o_rise  (w_ss_rise),
    .o_fall  (w_ss_fall)
  );

  assign w_unused_sync = ^{w_sclk_q, w_mosi_rise, w_mosi_fall};

  state_e            r_state;
  logic [6:0]        r_shift;
  logic [2:0]        r_bit_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [7:0]        r_tx;
  logic              r_wr_strobe;
  logic [7:0]        r_regs [NUM_REGS];

  logic [7:0]        w_byte;
  logic [ADDR_W-1:0] w_cmd_addr;
  logic [ADDR_W-1:0] w_addr_next;
  logic [7:0]        w_rd_cmd;
  logic [7:0]        w_rd_next;
  logic              w_addr_hit;

  assign w_byte      = {r_shift, w_mosi_q};
  assign w_cmd_addr  = w_byte[CMD_ADDR_MSB:CMD_ADDR_LSB];
  assign w_addr_next = next_addr(r_addr, NUM_REGS);

  // Unimplemented addresses read as INVALID_RD and are never hit for writes.
  always_comb begin
    w_rd_cmd   = INVALID_RD;
    w_rd_next  = INVALID_RD;
    w_addr_hit = 1'b0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (w_cmd_addr == ADDR_W'(i))  w_rd_cmd   = r_regs[i];
      if (w_addr_next == ADDR_W'(i)) w_rd_next  = r_regs[i];
      if (r_addr == ADDR_W'(i))      w_addr_hit = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_tx        <= '0;
      r_wr_strobe <= 1'b0;
      for (int i = 0; i < int'(NUM_REGS); i++) r_regs[i] <= '0;
    end else begin
      r_wr_strobe <= 1'b0;
      if (w_ss_rise) begin
        // Deselect aborts any partial byte; registers keep their contents.
        r_state   <= StIdle;
        r_shift   <= '0;
        r_bit_cnt <= '0;
        r_tx      <= '0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (w_ss_fall) begin
              r_state   <= StCmd;
              r_shift   <= '0;
              r_bit_cnt <= '0;
              r_tx      <= '0;
            end
          end
          StCmd: begin
            if (w_sclk_rise) begin
              r_shift   <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_state <= StData;
                r_write <= w_byte[CMD_WR_BIT];
                r_addr  <= w_cmd_addr;
                r_tx    <= w_byte[CMD_WR_BIT] ? 8'h00 : w_rd_cmd;
              end
            end
          end
          StData: begin
            if (w_sclk_rise) begin
              r_shift   <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                if (r_write && w_addr_hit) begin
                  for (int i = 0; i < int'(NUM_REGS); i++) begin
                    if (r_addr == ADDR_W'(i)) r_regs[i] <= w_byte;
                  end
                  r_wr_strobe <= 1'b1;
                end
                r_addr <= w_addr_next;
                r_tx   <= r_write ? 8'h00 : w_rd_next;
              end
            end else if (w_sclk_fall && r_bit_cnt != 3'd0) begin
              // The fall right after a reload must not shift, or the MSB would be lost.
              r_tx <= {r_tx[6:0], 1'b0};
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign spi.miso      = r_tx[7];
  assign spi.wr_strobe = r_wr_strobe;
  assign spi.busy      = ~w_ss_q;
  assign spi.slv_reg   = r_regs;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed and randomized SPI transactions against a behavioural register-file model.
module tb_spi_slave_regfile;

  localparam int NREGS = 6;
  localparam int HALF  = 4;  // sclk = clk/8

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   strobe_cnt = 0;

  logic [7:0] model [NREGS];
  logic [7:0] tx_buf [0:4];
  logic [7:0] rx_buf [0:4];
  logic [7:0] exp_rx [0:3];

  spi_slave_regfile_if #(.NUM_REGS(NREGS)) bus ();

  spi_slave_regfile #(.SYNC_STAGES(2), .NUM_REGS(NREGS)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .spi     (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.wr_strobe === 1'b1) strobe_cnt++;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NREGS; i++)
      check8($sformatf("%s_reg%0d", tag, i), bus.slv_reg[i], model[i]);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      bus.mosi = tx[i];
      repeat (HALF) @(negedge clk);
      bus.sclk = 1'b1;
      rx[i] = bus.miso;
      repeat (HALF) @(negedge clk);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic spi_frame(input int nbytes, input int last_bits);
    bus.ss_n = 1'b0;
    repeat (HALF) @(negedge clk);
    check8("busy_in_frame", {7'd0, bus.busy}, 8'h01);
    for (int b = 0; b < nbytes; b++) spi_bits(tx_buf[b], 8, rx_buf[b]);
    if (last_bits > 0) spi_bits(tx_buf[nbytes], last_bits, rx_buf[nbytes]);
    repeat (HALF) @(negedge clk);
    bus.ss_n = 1'b1;
    repeat (8) @(negedge clk);
    check8("busy_after_frame", {7'd0, bus.busy}, 8'h00);
    check8("miso_idle", {7'd0, bus.miso}, 8'h00);
  endtask

  // Command in cmd, n data bytes taken from tx_buf[1..n].
  task automatic run_txn(input logic [7:0] cmd, input int n);
    int s0, exp_str, addr;
    s0 = strobe_cnt;
    exp_str = 0;
    addr = int'(cmd[2:0]);
    for (int k = 0; k < n; k++) begin
      if (cmd[7]) begin
        exp_rx[k] = 8'h00;
        if (addr < NREGS) begin
          model[addr] = tx_buf[k+1];
          exp_str++;
        end
      end else begin
        exp_rx[k] = (addr < NREGS) ? model[addr] : 8'h00;
      end
      addr = addr + 1;
      if (addr == NREGS || addr == 8) addr = 0;
    end
    tx_buf[0] = cmd;
    spi_frame(n + 1, 0);
    check8("cmd_miso", rx_buf[0], 8'h00);
    for (int k = 0; k < n; k++) check8($sformatf("rx_byte%0d", k), rx_buf[k+1], exp_rx[k]);
    check32("strobes", strobe_cnt - s0, exp_str);
    check_regs("txn");
  endtask

  initial begin
    int s0;
    logic [7:0] cmd;
    int n;

    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    bus.ss_n = 1'b1;
    rst_n    = 1'b0;
    for (int i = 0; i < NREGS; i++) model[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_regs("reset");
    check8("reset_busy", {7'd0, bus.busy}, 8'h00);
    check8("reset_miso", {7'd0, bus.miso}, 8'h00);
    check8("reset_strobe", {7'd0, bus.wr_strobe}, 8'h00);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Stray sclk activity while deselected must be ignored.
    s0 = strobe_cnt;
    spi_bits(8'hFF, 8, rx_buf[0]);
    check32("desel_strobes", strobe_cnt - s0, 0);
    check_regs("desel");

    // Single write to reg1.
    tx_buf[1] = 8'hA5;
    run_txn(8'h81, 1);
    check8("wr_reg1_const", bus.slv_reg[1], 8'hA5);

    // Burst write wrapping from reg5 to reg0.
    tx_buf[1] = 8'h11; tx_buf[2] = 8'h22; tx_buf[3] = 8'h33;
    run_txn(8'h85, 3);
    check8("burst_reg5", bus.slv_reg[5], 8'h11);
    check8("burst_reg0", bus.slv_reg[0], 8'h22);

    // Preload reg2 then read it back with two dummy bytes.
    tx_buf[1] = 8'h3C;
    run_txn(8'h82, 1);
    tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    run_txn(8'h02, 2);
    check8("rd_reg2_const", rx_buf[1], 8'h3C);

    // Invalid addresses: write ignored, read returns zero.
    tx_buf[1] = 8'hFF;
    run_txn(8'h86, 1);
    tx_buf[1] = 8'h00;
    run_txn(8'h07, 1);

    // Deselect mid-byte discards the partial byte.
    s0 = strobe_cnt;
    tx_buf[0] = 8'h80; tx_buf[1] = 8'hFF;
    spi_frame(1, 4);
    check32("abort_strobes", strobe_cnt - s0, 0);
    check_regs("abort");
    tx_buf[1] = 8'h5A;
    run_txn(8'h80, 1);

    // Reset during a data byte.
    bus.ss_n = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bits(8'h80, 8, rx_buf[0]);
    spi_bits(8'hFF, 4, rx_buf[1]);
    rst_n = 1'b0;
    for (int i = 0; i < NREGS; i++) model[i] = 8'h00;
    repeat (2) @(negedge clk);
    check_regs("mid_reset");
    check8("mid_reset_busy", {7'd0, bus.busy}, 8'h00);
    check8("mid_reset_miso", {7'd0, bus.miso}, 8'h00);
    bus.ss_n = 1'b1;
    bus.sclk = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    tx_buf[1] = 8'h77;
    run_txn(8'h83, 1);

    // Randomized reads and writes, including unimplemented addresses.
    for (int t = 0; t < 24; t++) begin
      cmd = 8'($urandom);
      n = $urandom_range(1, 3);
      for (int k = 1; k <= n; k++) tx_buf[k] = 8'($urandom);
      run_txn(cmd, n);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
